ltm_scanout: RTL

//  Parametrised LCD scanout engine for the LTM panel: generates HD/VD/DEN timing from programmable

---
 rtl/ltm_pkg.sv | 51 +++++
 rtl/ltm_scanout_if.sv | 15 +
 rtl/ltm_timing_gen.sv | 57 +++++
 rtl/ltm_scanout.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ltm_pkg.sv
// Shared types and helpers for the LTM scanout engine.
//   rgb565_t / rgb888_t : packed pixel formats
//   scan_state_e        : stream-alignment FSM encoding
//   rgb565_to_888       : bit-replicating colour expansion
//   bar_color           : colour of test-pattern bar 0..7
package ltm_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } scan_state_e;

  // Replicating the MSBs into the new LSBs maps full-scale to 8'hFF.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

  function automatic rgb888_t bar_color(input logic [2:0] idx);
    rgb888_t o;
    case (idx)
      3'd0:    o = 24'hFFFFFF;  // white
      3'd1:    o = 24'hFFFF00;  // yellow
      3'd2:    o = 24'h00FFFF;  // cyan
      3'd3:    o = 24'h00FF00;  // green
      3'd4:    o = 24'hFF00FF;  // magenta
      3'd5:    o = 24'hFF0000;  // red
      3'd6:    o = 24'h0000FF;  // blue
      default: o = 24'h000000;  // black
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ltm_scanout_if.sv
// Pixel stream from the frame-fetch FIFO into the scanout engine.
//   pix_data  : RGB565 word
//   pix_sof   : word is the first pixel of a frame
//   pix_valid : source has a word
//   pix_ready : sink takes the word this cycle
// master = fetch side, slave = scanout side.
interface ltm_scanout_if;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_sof, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_sof, input pix_valid, output pix_ready);
endinterface

// File: rtl/ltm_timing_gen.sv
// Raster counters for the LTM panel.
//   clk, reset_n : pixel clock, synchronous active-low reset
//   h_cnt        : horizontal position (active, FP, SYNC, BP order)
//   active       : inside visible area
//   hd, vd       : active-low syncs (unregistered)
//   first_px     : position (0,0)
//   act_end      : position (0,V_ACTIVE), first clock after the visible area
module ltm_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 215,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 22,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] h_cnt,
  output logic          active,
  output logic          hd,
  output logic          vd,
  output logic          first_px,
  output logic          act_end
);

  logic [VW-1:0] v_cnt;
  logic [31:0]   hx, vx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Compare in 32 bits so end-of-sync bounds equal to the total still fit.
  assign hx = 32'(h_cnt);
  assign vx = 32'(v_cnt);

  assign active   = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
  assign hd       = !((hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC)));
  assign vd       = !((vx >= 32'(V_ACTIVE + V_FP)) && (vx < 32'(V_ACTIVE + V_FP + V_SYNC)));
  assign first_px = (hx == 32'd0) && (vx == 32'd0);
  assign act_end  = (hx == 32'd0) && (vx == 32'(V_ACTIVE));

endmodule

// File: rtl/ltm_scanout.sv
// LTM panel scanout: raster timing plus frame-aligned RGB565 stream consumer.
//   clk, reset_n           : pixel clock, synchronous active-low reset
//   pix (slave)            : RGB565 stream with start-of-frame marker
//   pattern_sel            : colour-bar override (only with LTM_SCANOUT_TEST_PATTERN_EN)
//   ltm_r/g/b, ltm_den     : registered panel data, aligned with each other
//   ltm_hd, ltm_vd         : registered active-low syncs
//   frame_start            : pulse with the first displayed pixel of a frame
//   underflow              : pulse per starved active pixel
//   err_count              : saturating underflow + misalignment count
// Build option: define LTM_SCANOUT_TEST_PATTERN_EN for the pattern_sel port.
module ltm_scanout
  import ltm_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 1,
  parameter int H_BP     = 215,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 1,
  parameter int V_BP     = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  ltm_scanout_if.slave     pix,
`ifdef LTM_SCANOUT_TEST_PATTERN_EN
  input  logic             pattern_sel,
`endif
  output logic [7:0]       ltm_r,
  output logic [7:0]       ltm_g,
  output logic [7:0]       ltm_b,
  output logic             ltm_den,
  output logic             ltm_hd,
  output logic             ltm_vd,
  output logic             frame_start,
  output logic             underflow,
  output logic [15:0]      err_count
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

  localparam logic [1:0] ST_SYNC  = SYNC;
  localparam logic [1:0] ST_ARMED = ARMED;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [HW-1:0] h_cnt;
  logic          active, hd_c, vd_c, first_px, act_end;

  ltm_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tg (
    .clk      (clk),
    .reset_n  (reset_n),
    .h_cnt    (h_cnt),
    .active   (active),
    .hd       (hd_c),
    .vd       (vd_c),
    .first_px (first_px),
    .act_end  (act_end)
  );

  logic pat_on;
`ifdef LTM_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0] bar_sel;
  assign pat_on  = pattern_sel;
  assign bar_sel = 3'(32'(h_cnt) / 32'(BAR_W));
`else
  logic unused_h;
  assign pat_on   = 1'b0;
  assign unused_h = &{1'b0, h_cnt};
`endif

  logic [1:0] state, nxt;
  logic       run_now, head_bad, starve, misalign, take, err_evt, ready_c;
  rgb565_t    px;
  rgb888_t    rgb_nxt, rgb_q;

  assign px = pix.pix_data;

  // ARMED behaves as RUN in the (0,0) cycle so that pixel is consumed on time.
  assign run_now  = !pat_on && ((state == ST_RUN) ||
                                (state == ST_ARMED && active && first_px));
  // Head must carry sof exactly at (0,0); otherwise it is left in place.
  assign head_bad = pix.pix_valid && (pix.pix_sof != first_px);
  assign starve   = run_now && active && !pix.pix_valid;
  assign misalign = run_now && active && head_bad;
  assign take     = run_now && active && pix.pix_valid && !head_bad;
  assign err_evt  = starve || misalign;

  always_comb begin
    nxt     = state;
    ready_c = 1'b0;
    if (pat_on) begin
      nxt = ST_SYNC;
    end else begin
      case (state)
        ST_SYNC: begin
          // Swallow everything except an sof head, which is held for ARMED.
          ready_c = !(pix.pix_valid && pix.pix_sof);
          if (pix.pix_valid && pix.pix_sof) nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (run_now) begin
            ready_c = !head_bad;
            nxt     = err_evt ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          ready_c = active && !head_bad;
          if (err_evt) nxt = ST_DRAIN;
        end
        default: begin
          if (act_end) nxt = ST_SYNC;
        end
      endcase
    end
  end

  // Hold ready low while reset is asserted so nothing is taken during reset.
  assign pix.pix_ready = reset_n && ready_c;

  always_comb begin
    rgb_nxt = '0;
    if (take) rgb_nxt = rgb565_to_888(px);
`ifdef LTM_SCANOUT_TEST_PATTERN_EN
    else if (pat_on && active) rgb_nxt = bar_color(bar_sel);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_SYNC;
      rgb_q       <= '0;
      ltm_den     <= 1'b0;
      ltm_hd      <= 1'b1;
      ltm_vd      <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= nxt;
      rgb_q       <= rgb_nxt;
      ltm_den     <= active;
      ltm_hd      <= hd_c;
      ltm_vd      <= vd_c;
      frame_start <= take && first_px;
      underflow   <= starve;
      if (err_evt && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  assign ltm_r = rgb_q.r;
  assign ltm_g = rgb_q.g;
  assign ltm_b = rgb_q.b;

endmodule
